raster_prim_arbiter: RTL and testbench

Sequences and merges a rasterizer slice group. On a start pulse it launches NUM_INPUTS raster memory fetch units together, then round-robin arbitrates their primitive streams into one registered output toward the rasterizer core. It tracks completion and reports a done pulse and an emitted-primitive count. It sits between the per-slice raster memory units and the shared edge-function/tile-evaluation datapath.

---
 rtl/raster_prim_arbiter_if.sv | 38 +++
 rtl/raster_prim_arbiter.sv | 139 +++++++++++++
 tb/tb_raster_prim_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_prim_arbiter_if.sv
// Primitive bus between the raster memory units, the arbiter and the core.
// Ports: mem_busy/in_* from the memory units, out_* toward the rasterizer.
interface raster_prim_arbiter_if #(
   parameter int NUM_INPUTS = 4,
   parameter int PID_BITS   = 16,
   parameter int DIM_BITS   = 15,
   parameter int DATA_BITS  = 32,
   parameter int SRC_BITS   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
);
   logic [NUM_INPUTS-1:0]             mem_busy;
   logic [NUM_INPUTS-1:0]             in_valid;
   logic [NUM_INPUTS*PID_BITS-1:0]    in_pid;
   logic [NUM_INPUTS*DIM_BITS-1:0]    in_xloc;
   logic [NUM_INPUTS*DIM_BITS-1:0]    in_yloc;
   logic [NUM_INPUTS*9*DATA_BITS-1:0] in_edges;
   logic [NUM_INPUTS-1:0]             in_ready;
   logic                              out_valid;
   logic [PID_BITS-1:0]               out_pid;
   logic [DIM_BITS-1:0]               out_xloc;
   logic [DIM_BITS-1:0]               out_yloc;
   logic [9*DATA_BITS-1:0]            out_edges;
   logic [SRC_BITS-1:0]               out_src;
   logic                              out_ready;

   modport slave (
      input  mem_busy, in_valid, in_pid, in_xloc,
      input  in_yloc, in_edges, out_ready,
      output in_ready, out_valid, out_pid, out_xloc,
      output out_yloc, out_edges, out_src
   );

   modport master (
      output mem_busy, in_valid, in_pid, in_xloc,
      output in_yloc, in_edges, out_ready,
      input  in_ready, out_valid, out_pid, out_xloc,
      input  out_yloc, out_edges, out_src
   );
endinterface

// File: rtl/raster_prim_arbiter.sv
// Launches a raster slice group and round-robin merges its primitive streams.
// Ports: clk, reset, start, busy, done, prim_count, mem_start, bus (slave).
module raster_prim_arbiter #(
   parameter int NUM_INPUTS = 4,
   parameter int PID_BITS   = 16,
   parameter int DIM_BITS   = 15,
   parameter int DATA_BITS  = 32,
   parameter int SRC_BITS   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [31:0] prim_count,
   output logic        mem_start,
   raster_prim_arbiter_if.slave bus
);
   localparam int EW = 9 * DATA_BITS;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state_q, state_d;
   logic armed_q;
   logic [SRC_BITS-1:0] rr_q;
   logic out_valid_q;
   logic [PID_BITS-1:0] pid_q;
   logic [DIM_BITS-1:0] xloc_q, yloc_q;
   logic [EW-1:0] edges_q;
   logic [SRC_BITS-1:0] src_q;

   logic [PID_BITS-1:0] pid_a [NUM_INPUTS];
   logic [DIM_BITS-1:0] xloc_a [NUM_INPUTS];
   logic [DIM_BITS-1:0] yloc_a [NUM_INPUTS];
   logic [EW-1:0] edges_a [NUM_INPUTS];

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
      assign pid_a[i]   = bus.in_pid[i*PID_BITS +: PID_BITS];
      assign xloc_a[i]  = bus.in_xloc[i*DIM_BITS +: DIM_BITS];
      assign yloc_a[i]  = bus.in_yloc[i*DIM_BITS +: DIM_BITS];
      assign edges_a[i] = bus.in_edges[i*EW +: EW];
   end

   logic [NUM_INPUTS-1:0] grant;
   logic [SRC_BITS-1:0] win;
   logic [SRC_BITS-1:0] idx;
   logic found;
   logic accept;
   logic in_fire;
   logic out_fire;

   // First valid requester at or after the rr pointer, wrapping.
   always_comb begin
      grant = '0;
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         idx = SRC_BITS'((int'(rr_q) + k) % NUM_INPUTS);
         if (!found && bus.in_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win        = idx;
         end
      end
   end

   assign accept   = ~out_valid_q | bus.out_ready;
   assign in_fire  = found & accept;
   assign out_fire = out_valid_q & bus.out_ready;

   assign bus.in_ready  = grant & {NUM_INPUTS{accept}};
   assign bus.out_valid = out_valid_q;
   assign bus.out_pid   = pid_q;
   assign bus.out_xloc  = xloc_q;
   assign bus.out_yloc  = yloc_q;
   assign bus.out_edges = edges_q;
   assign bus.out_src   = src_q;

   assign busy = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            // armed hides the cycle before the units raise mem_busy
            if (armed_q && ~|bus.mem_busy && ~|bus.in_valid)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (!out_valid_q || bus.out_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         armed_q     <= 1'b0;
         mem_start   <= 1'b0;
         prim_count  <= '0;
         out_valid_q <= 1'b0;
         rr_q        <= '0;
      end else begin
         state_q   <= state_d;
         mem_start <= (state_q == IDLE) && start;
         armed_q   <= (state_q == RUN);
         if ((state_q == IDLE) && start)
            prim_count <= {31'd0, out_fire};
         else if (out_fire && (prim_count != '1))
            prim_count <= prim_count + 32'd1;
         if (in_fire) begin
            out_valid_q <= 1'b1;
            rr_q <= (win == SRC_BITS'(NUM_INPUTS - 1)) ?
                    '0 : win + 1'b1;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         pid_q   <= pid_a[win];
         xloc_q  <= xloc_a[win];
         yloc_q  <= yloc_a[win];
         edges_q <= edges_a[win];
         src_q   <= win;
      end
   end
endmodule

// File: tb/tb_raster_prim_arbiter.sv
// Scoreboard bench for raster_prim_arbiter with four memory units.
// Drives per-unit queues, checks merged order, handshakes and job control.
module tb_raster_prim_arbiter;
   localparam int NI = 4;
   localparam int PB = 16;
   localparam int DB = 15;
   localparam int WB = 32;
   localparam int SB = 2;
   localparam int EW = 9 * WB;

   typedef struct packed {
      logic [SB-1:0] src;
      logic [PB-1:0] pid;
      logic [DB-1:0] x;
      logic [DB-1:0] y;
      logic [EW-1:0] e;
   } item_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic busy, done, mem_start;
   logic [31:0] prim_count;

   raster_prim_arbiter_if #(
      .NUM_INPUTS(NI), .PID_BITS(PB),
      .DIM_BITS(DB), .DATA_BITS(WB)
   ) bus ();

   raster_prim_arbiter #(
      .NUM_INPUTS(NI), .PID_BITS(PB),
      .DIM_BITS(DB), .DATA_BITS(WB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .busy(busy),
      .done(done),
      .prim_count(prim_count),
      .mem_start(mem_start),
      .bus(bus)
   );

   always #5 clk = ~clk;

   item_t uq [NI][$];
   item_t exq [$];
   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   int done_cnt = 0;
   int ms_cnt = 0;
   int fire_n = 0;
   int fire_first = 0;
   int fire_last = 0;

   task automatic chk(string tag, logic [383:0] got, logic [383:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic item_t mk(int u, int pid);
      item_t it;
      it.src = SB'(u);
      it.pid = PB'(pid);
      it.x = DB'($urandom);
      it.y = DB'($urandom);
      for (int j = 0; j < 9; j++) it.e[j*WB +: WB] = $urandom;
      return it;
   endfunction

   task automatic load(int u, int pid);
      item_t it;
      it = mk(u, pid);
      uq[u].push_back(it);
      exq.push_back(it);
   endtask

   task automatic drive();
      for (int i = 0; i < NI; i++) begin
         if (uq[i].size() > 0) begin
            bus.in_valid[i] = 1'b1;
            bus.in_pid[i*PB +: PB] = uq[i][0].pid;
            bus.in_xloc[i*DB +: DB] = uq[i][0].x;
            bus.in_yloc[i*DB +: DB] = uq[i][0].y;
            bus.in_edges[i*EW +: EW] = uq[i][0].e;
         end else begin
            bus.in_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      item_t got, e, d;
      @(negedge clk);
      if (done) done_cnt++;
      if (mem_start) ms_cnt++;
      if (bus.out_valid && bus.out_ready) begin
         got = {bus.out_src, bus.out_pid, bus.out_xloc,
                bus.out_yloc, bus.out_edges};
         if (fire_n == 0) fire_first = cyc_n;
         fire_last = cyc_n;
         fire_n++;
         if (exq.size() == 0) begin
            chk("unexp_out", 1, 0);
         end else begin
            e = exq.pop_front();
            chk("out_item", got, e);
         end
      end
      for (int i = 0; i < NI; i++)
         if (bus.in_valid[i] && bus.in_ready[i]) d = uq[i].pop_front();
      @(posedge clk);
      #1;
      cyc_n++;
      drive();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(int bound);
      int d0;
      d0 = done_cnt;
      for (int n = 0; n < bound && done_cnt == d0; n++) cyc();
      chk("done_seen", done_cnt - d0, 1);
   endtask

   task automatic drain(int bound);
      for (int n = 0; n < bound && exq.size() > 0; n++) cyc();
      chk("drained", exq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bus.mem_busy = '0;
      bus.in_valid = '0;
      bus.in_pid = '0;
      bus.in_xloc = '0;
      bus.in_yloc = '0;
      bus.in_edges = '0;
      bus.out_ready = 1'b1;

      repeat (3) cyc();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mstart", mem_start, 0);
      chk("rst_count", prim_count, 0);
      chk("rst_oval", bus.out_valid, 0);
      reset = 1'b0;
      cyc();

      // empty job
      pulse_start();
      chk("t1_mstart", mem_start, 1);
      chk("t1_busy", busy, 1);
      chk("t1_count", prim_count, 0);
      cyc();
      chk("t1_mstart_off", mem_start, 0);
      chk("t1_done_early", done, 0);
      cyc();
      chk("t1_done", done, 1);
      chk("t1_busy_done", busy, 1);
      cyc();
      chk("t1_done_off", done, 0);
      chk("t1_idle", busy, 0);

      // four units, two primitives each
      fire_n = 0;
      pulse_start();
      bus.mem_busy = '1;
      for (int r = 0; r < 2; r++)
         for (int u = 0; u < NI; u++) load(u, 100 + r * NI + u);
      drive();
      drain(40);
      chk("t2_n", fire_n, 8);
      chk("t2_gap", fire_last - fire_first, 7);
      bus.mem_busy = '0;
      wait_done(10);
      chk("t2_count", prim_count, 8);

      // lone requester, back to back
      fire_n = 0;
      pulse_start();
      bus.mem_busy = 4'b0100;
      for (int p = 10; p < 15; p++) load(2, p);
      drive();
      drain(40);
      chk("t3_n", fire_n, 5);
      chk("t3_gap", fire_last - fire_first, 4);
      bus.mem_busy = '0;
      wait_done(10);
      chk("t3_count", prim_count, 5);

      // downstream stall
      pulse_start();
      bus.mem_busy = 4'b0010;
      for (int p = 200; p < 203; p++) load(1, p);
      drive();
      cyc();
      bus.out_ready = 1'b0;
      for (int n = 0; n < 4; n++) begin
         cyc();
         chk("t4_oval", bus.out_valid, 1);
         chk("t4_pid", bus.out_pid, 200);
         chk("t4_iready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("t4_release", bus.in_ready, 4'b0010);
      drain(40);
      bus.mem_busy = '0;
      wait_done(10);
      chk("t4_count", prim_count, 3);

      // start ignored while running
      ms_cnt = 0;
      pulse_start();
      chk("t5_count_clr", prim_count, 0);
      bus.mem_busy = 4'b0001;
      cyc();
      cyc();
      pulse_start();
      chk("t5_no_mstart", mem_start, 0);
      chk("t5_busy", busy, 1);
      bus.mem_busy = '0;
      wait_done(10);
      chk("t5_ms_cnt", ms_cnt, 1);
      ms_cnt = 0;
      pulse_start();
      chk("t5_restart", mem_start, 1);
      wait_done(10);
      chk("t5_ms_cnt2", ms_cnt, 1);
      chk("t5_count", prim_count, 0);

      // reset while a primitive is buffered
      pulse_start();
      bus.mem_busy = 4'b0001;
      load(0, 300);
      load(0, 301);
      drive();
      cyc();
      cyc();
      bus.out_ready = 1'b0;
      cyc();
      chk("t6_pre_oval", bus.out_valid, 1);
      chk("t6_pre_count", prim_count, 1);
      begin
         int d0;
         d0 = done_cnt;
         reset = 1'b1;
         cyc();
         chk("t6_oval", bus.out_valid, 0);
         chk("t6_busy", busy, 0);
         chk("t6_done", done, 0);
         chk("t6_count", prim_count, 0);
         reset = 1'b0;
         for (int i = 0; i < NI; i++) uq[i].delete();
         exq.delete();
         bus.mem_busy = '0;
         bus.out_ready = 1'b1;
         drive();
         cyc();
         cyc();
         chk("t6_no_done", done_cnt - d0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
